// File: rtl/filter_mode_ctrl.sv
// PS/2-driven filter mode / brightness controller with frame-boundary commit.
// Optional feature: FILTER_MODE_CTRL_ESC_RESET_EN (Esc restores default shadow config).
//
// state        | meaning
// S_IDLE       | waiting for a make code or a prefix byte
// S_BREAK      | F0 seen; next byte is a release and is discarded
// S_EXT        | E0 seen; next byte is an extended make unless it is F0
// S_EXT_BREAK  | E0 F0 seen; next byte is an extended release and is discarded
module filter_mode_ctrl #(
  parameter int unsigned NUM_MODES      = 6,
  parameter int unsigned BRIGHT_DEFAULT = 8
) (
  input  logic       clk,
  input  logic       btnC,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       frame_start,
  output logic [2:0] mode,
  output logic [3:0] brightness,
  output logic       pending,
  output logic       cfg_changed
);

  localparam logic [3:0] BRIGHT_RST = 4'(BRIGHT_DEFAULT);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

  state_t     state_q, state_d;
  logic [2:0] shadow_mode_q, shadow_mode_d;
  logic [3:0] shadow_bright_q, shadow_bright_d;
  logic [2:0] mode_q, mode_d;
  logic [3:0] bright_q, bright_d;
  logic       pending_q, pending_d;
  logic       cfg_changed_q, cfg_changed_d;

  logic       digit_hit;
  logic [2:0] digit;

  always_comb begin
    digit_hit = 1'b1;
    digit     = 3'd0;
    case (rx_byte)
      8'h45:   digit = 3'd0;
      8'h16:   digit = 3'd1;
      8'h1E:   digit = 3'd2;
      8'h26:   digit = 3'd3;
      8'h25:   digit = 3'd4;
      8'h2E:   digit = 3'd5;
      8'h36:   digit = 3'd6;
      8'h3D:   digit = 3'd7;
      default: digit_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    shadow_mode_d   = shadow_mode_q;
    shadow_bright_d = shadow_bright_q;
    mode_d          = mode_q;
    bright_d        = bright_q;
    cfg_changed_d   = 1'b0;

    // Commit samples the shadow before any byte arriving in the same cycle.
    if (frame_start) begin
      mode_d        = shadow_mode_q;
      bright_d      = shadow_bright_q;
      cfg_changed_d = (shadow_mode_q != mode_q) || (shadow_bright_q != bright_q);
    end

    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_byte == 8'hF0) begin
            state_d = S_BREAK;
          end else if (rx_byte == 8'hE0) begin
            state_d = S_EXT;
          end else if (digit_hit && ({29'd0, digit} < NUM_MODES)) begin
            shadow_mode_d = digit;
          end
`ifdef FILTER_MODE_CTRL_ESC_RESET_EN
          else if (rx_byte == 8'h76) begin
            shadow_mode_d   = 3'd0;
            shadow_bright_d = BRIGHT_RST;
          end
`endif
        end
        S_EXT: begin
          if (rx_byte == 8'hF0) begin
            state_d = S_EXT_BREAK;
          end else begin
            state_d = S_IDLE;
            if (rx_byte == 8'h75 && shadow_bright_q != 4'd15)
              shadow_bright_d = shadow_bright_q + 4'd1;
            else if (rx_byte == 8'h72 && shadow_bright_q != 4'd0)
              shadow_bright_d = shadow_bright_q - 4'd1;
          end
        end
        S_BREAK, S_EXT_BREAK: state_d = S_IDLE;
        default:              state_d = S_IDLE;
      endcase
    end

    pending_d = (shadow_mode_d != mode_d) || (shadow_bright_d != bright_d);
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      state_q         <= S_IDLE;
      shadow_mode_q   <= 3'd0;
      shadow_bright_q <= BRIGHT_RST;
      mode_q          <= 3'd0;
      bright_q        <= BRIGHT_RST;
      pending_q       <= 1'b0;
      cfg_changed_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      shadow_mode_q   <= shadow_mode_d;
      shadow_bright_q <= shadow_bright_d;
      mode_q          <= mode_d;
      bright_q        <= bright_d;
      pending_q       <= pending_d;
      cfg_changed_q   <= cfg_changed_d;
    end
  end

  assign mode        = mode_q;
  assign brightness  = bright_q;
  assign pending     = pending_q;
  assign cfg_changed = cfg_changed_q;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Bench for filter_mode_ctrl: directed scenarios plus randomized byte streams
// checked against a keyboard-level reference model.
module tb_filter_mode_ctrl;

  logic       clk = 1'b0;
  logic       btnC = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [2:0] mode;
  logic [3:0] brightness;
  logic       pending;
  logic       cfg_changed;

  int tests = 0;
  int fails = 0;

  filter_mode_ctrl #(.NUM_MODES(6), .BRIGHT_DEFAULT(8)) dut (
    .clk(clk), .btnC(btnC), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_start(frame_start), .mode(mode), .brightness(brightness),
    .pending(pending), .cfg_changed(cfg_changed)
  );

  always #5 clk = ~clk;

  // Reference model: keyboard meaning of the byte stream.
  int  m_shadow_mode, m_shadow_bright, m_mode, m_bright;
  bit  m_changed;
  bit  m_after_e0;       // last byte was an E0 prefix
  bit  m_release_next;   // next byte names a released key
  byte digit_codes [8] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};

  function automatic bit m_pending();
    return (m_shadow_mode != m_mode) || (m_shadow_bright != m_bright);
  endfunction

  task automatic model_reset();
    m_shadow_mode = 0; m_shadow_bright = 8; m_mode = 0; m_bright = 8;
    m_changed = 0; m_after_e0 = 0; m_release_next = 0;
  endtask

  task automatic model_byte(input byte b);
    if (m_release_next) begin
      m_release_next = 0; m_after_e0 = 0;
    end else if (b == 8'hF0) begin
      m_release_next = 1; m_after_e0 = 0;
    end else if (b == 8'hE0 && !m_after_e0) begin
      m_after_e0 = 1;
    end else if (m_after_e0) begin
      m_after_e0 = 0;
      if (b == 8'h75) m_shadow_bright = (m_shadow_bright >= 15) ? 15 : m_shadow_bright + 1;
      if (b == 8'h72) m_shadow_bright = (m_shadow_bright <= 0) ? 0 : m_shadow_bright - 1;
    end else begin
      for (int i = 0; i < 8; i++)
        if (digit_codes[i] == b && i < 6) m_shadow_mode = i;
`ifdef FILTER_MODE_CTRL_ESC_RESET_EN
      if (b == 8'h76) begin m_shadow_mode = 0; m_shadow_bright = 8; end
`endif
    end
  endtask

  // One clock: drive inputs, advance the model, leave outputs ready to sample.
  task automatic cyc(input bit r, input bit v, input byte b, input bit f);
    @(negedge clk);
    btnC = r; rx_valid = v; rx_byte = b; frame_start = f;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else begin
      m_changed = 0;
      if (f) begin
        m_changed = (m_shadow_mode != m_mode) || (m_shadow_bright != m_bright);
        m_mode = m_shadow_mode; m_bright = m_shadow_bright;
      end
      if (v) model_byte(b);
    end
    btnC = 0; rx_valid = 0; rx_byte = 8'h00; frame_start = 0;
  endtask

  task automatic send(input byte b);
    cyc(0, 1, b, 0);
  endtask

  task automatic frame();
    cyc(0, 0, 8'h00, 1);
  endtask

  task automatic test_reset();
    cyc(1, 0, 8'h00, 0);
    tests++;
    if (mode !== 3'd0 || brightness !== 4'd8 || pending !== 1'b0 || cfg_changed !== 1'b0) begin
      fails++;
      $display("FAIL reset: got mode=%0d bright=%0d pend=%0b chg=%0b, want 0/8/0/0",
               mode, brightness, pending, cfg_changed);
    end
  endtask

  task automatic test_mode_commit();
    cyc(1, 0, 8'h00, 0);
    send(8'h16);
    tests++;
    if (pending !== 1'b1 || mode !== 3'd0) begin
      fails++; $display("FAIL pend_before_commit: got pend=%0b mode=%0d, want 1/0", pending, mode);
    end
    frame();
    tests++;
    if (mode !== 3'd1 || cfg_changed !== 1'b1 || pending !== 1'b0) begin
      fails++; $display("FAIL commit: got mode=%0d chg=%0b pend=%0b, want 1/1/0", mode, cfg_changed, pending);
    end
    cyc(0, 0, 8'h00, 0);
    tests++;
    if (cfg_changed !== 1'b0) begin
      fails++; $display("FAIL chg_one_cycle: got chg=%0b, want 0", cfg_changed);
    end
  endtask

  task automatic test_last_wins();
    cyc(1, 0, 8'h00, 0);
    send(8'h16); send(8'h1E); send(8'h3D);
    frame();
    tests++;
    if (mode !== 3'd2 || brightness !== 4'd8 || cfg_changed !== 1'b1) begin
      fails++; $display("FAIL last_wins: got mode=%0d bright=%0d chg=%0b, want 2/8/1", mode, brightness, cfg_changed);
    end
    frame();
    tests++;
    if (cfg_changed !== 1'b0 || mode !== 3'd2) begin
      fails++; $display("FAIL idle_frame: got chg=%0b mode=%0d, want 0/2", cfg_changed, mode);
    end
  endtask

  task automatic test_release();
    cyc(1, 0, 8'h00, 0);
    send(8'hF0); send(8'h45); send(8'h16); send(8'hF0); send(8'h16);
    frame();
    tests++;
    if (mode !== 3'd1) begin
      fails++; $display("FAIL release_ignored: got mode=%0d, want 1", mode);
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    frame();
    tests++;
    if (brightness !== 4'd8 || cfg_changed !== 1'b0 || pending !== 1'b0) begin
      fails++; $display("FAIL ext_release: got bright=%0d chg=%0b pend=%0b, want 8/0/0", brightness, cfg_changed, pending);
    end
  endtask

  task automatic test_saturate();
    cyc(1, 0, 8'h00, 0);
    for (int i = 0; i < 9; i++) begin send(8'hE0); send(8'h75); end
    frame();
    tests++;
    if (brightness !== 4'd15) begin
      fails++; $display("FAIL sat_high: got bright=%0d, want 15", brightness);
    end
    for (int i = 0; i < 20; i++) begin send(8'hE0); send(8'h72); end
    frame();
    tests++;
    if (brightness !== 4'd0 || cfg_changed !== 1'b1) begin
      fails++; $display("FAIL sat_low: got bright=%0d chg=%0b, want 0/1", brightness, cfg_changed);
    end
  endtask

  task automatic test_coincident();
    cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'h26, 1);
    tests++;
    if (mode !== 3'd0 || pending !== 1'b1 || cfg_changed !== 1'b0) begin
      fails++; $display("FAIL coincident: got mode=%0d pend=%0b chg=%0b, want 0/1/0", mode, pending, cfg_changed);
    end
    frame();
    tests++;
    if (mode !== 3'd3 || cfg_changed !== 1'b1 || pending !== 1'b0) begin
      fails++; $display("FAIL coincident_next: got mode=%0d chg=%0b pend=%0b, want 3/1/0", mode, cfg_changed, pending);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 8'h00, 0);
    send(8'h25);
    cyc(1, 1, 8'hE0, 1);  // reset wins over a coincident byte and frame
    tests++;
    if (mode !== 3'd0 || pending !== 1'b0 || cfg_changed !== 1'b0) begin
      fails++; $display("FAIL reset_priority: got mode=%0d pend=%0b chg=%0b, want 0/0/0", mode, pending, cfg_changed);
    end
    send(8'hE0);
    cyc(1, 0, 8'h00, 0);
    send(8'h75);
    frame();
    tests++;
    if (brightness !== 4'd8 || mode !== 3'd0 || pending !== 1'b0) begin
      fails++; $display("FAIL reset_mid_ext: got bright=%0d mode=%0d pend=%0b, want 8/0/0", brightness, mode, pending);
    end
  endtask

  task automatic test_esc();
    cyc(1, 0, 8'h00, 0);
    send(8'h25);
    for (int i = 0; i < 4; i++) begin send(8'hE0); send(8'h75); end
    frame();
    tests++;
    if (mode !== 3'd4 || brightness !== 4'd12) begin
      fails++; $display("FAIL esc_setup: got mode=%0d bright=%0d, want 4/12", mode, brightness);
    end
    send(8'h76);
    frame();
    tests++;
`ifdef FILTER_MODE_CTRL_ESC_RESET_EN
    if (mode !== 3'd0 || brightness !== 4'd8 || cfg_changed !== 1'b1) begin
      fails++; $display("FAIL esc_restore: got mode=%0d bright=%0d chg=%0b, want 0/8/1", mode, brightness, cfg_changed);
    end
`else
    if (mode !== 3'd4 || brightness !== 4'd12 || cfg_changed !== 1'b0) begin
      fails++; $display("FAIL esc_ignored: got mode=%0d bright=%0d chg=%0b, want 4/12/0", mode, brightness, cfg_changed);
    end
`endif
  endtask

  task automatic test_random();
    byte pool [14] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                       8'hF0, 8'hE0, 8'h75, 8'h72, 8'h76, 8'h00};
    int rfails = 0;
    cyc(1, 0, 8'h00, 0);
    for (int n = 0; n < 3000; n++) begin
      bit  r, v, f;
      byte b;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 11) == 0);
      b = pool[$urandom_range(0, 13)];
      if (b == 8'h00) b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) b = (b == 8'hE0) ? 8'h75 : 8'hE0;  // bias toward arrows
      cyc(r, v, b, f);
      tests++;
      if (int'(mode) != m_mode || int'(brightness) != m_bright ||
          pending !== m_pending() || cfg_changed !== m_changed) begin
        fails++;
        if (rfails++ < 10)
          $display("FAIL random[%0d]: got mode=%0d bright=%0d pend=%0b chg=%0b, want %0d/%0d/%0b/%0b",
                   n, mode, brightness, pending, cfg_changed, m_mode, m_bright, m_pending(), m_changed);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mode_commit();
    test_last_wins();
    test_release();
    test_saturate();
    test_coincident();
    test_reset_mid();
    test_esc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
